bcd_counter_chain: RTL and testbench

- Parametrised, fully synchronous multi-digit modulo counter, built from a chain of identical per-digit counters.
- Default configuration is BCD: DIGIT_MOD = 10, two digits, counting 00..99.
- Adds up/down counting, parallel load, count enable, terminal count, a wrap pulse and a sticky overflow flag.
- Used as the decade/timebase counter feeding display and timer logic. All flops are clocked by clk only; no derived or ripple clocks.

---
 rtl/bcd_cnt_pkg.sv | 18 +
 rtl/bcd_counter_chain_if.sv | 32 +++
 rtl/bcd_counter_chain_digit.sv | 49 ++++
 rtl/bcd_counter_chain.sv | 86 ++++++++
 tb/tb_bcd_counter_chain.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared types and helpers for the BCD / modulo counter chain.
//   DIGIT_W     : width of one digit field in the packed count
//   digit_t     : one digit field
//   clamp_digit : limits a loaded digit to the legal range 0..mod-1
package bcd_cnt_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Load values may carry out-of-range digits (e.g. 0xF in BCD); pin them to the max.
  function automatic digit_t clamp_digit(digit_t d, int mod);
    digit_t max_d;
    max_d = digit_t'(mod - 1);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control/status bundle for bcd_counter_chain.
//   en, up_dn, load, load_val, clr_ovf : controls from the master
//   count, tc, wrap, ovf_sticky        : status back from the counter
// load_val/count are packed DIGIT_W bits per digit, digit 0 in the LSBs.
interface bcd_counter_chain_if
  import bcd_cnt_pkg::*;
#(
  parameter int NUM_DIGITS = 2
);
  localparam int W = DIGIT_W * NUM_DIGITS;

  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         ovf_sticky;

  modport master (
    output en, up_dn, load, load_val, clr_ovf,
    input  count, tc, wrap, ovf_sticky
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_ovf,
    output count, tc, wrap, ovf_sticky
  );

endinterface

// File: rtl/bcd_counter_chain_digit.sv
// bcd_digit: one modulo-DIGIT_MOD digit of the counter chain.
//   clk, reset : clock, async active-high reset (q -> 0)
//   load       : parallel load of load_d (clamped), beats step
//   load_d     : raw load value for this digit
//   step       : advance one position in the up_dn direction
//   up_dn      : 1 = increment, 0 = decrement
//   q          : current digit value
//   at_max     : q == DIGIT_MOD-1
//   at_zero    : q == 0
module bcd_digit
  import bcd_cnt_pkg::*;
#(
  parameter int DIGIT_MOD = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  digit_t load_d,
  input  logic   step,
  input  logic   up_dn,
  output digit_t q,
  output logic   at_max,
  output logic   at_zero
);

  localparam digit_t MAX_D = digit_t'(DIGIT_MOD - 1);

  digit_t r_q;
  digit_t w_next;

  assign at_max  = (r_q == MAX_D);
  assign at_zero = (r_q == '0);
  assign q       = r_q;

  always_comb begin
    w_next = r_q;
    if (step) begin
      if (up_dn) w_next = at_max  ? '0    : r_q + digit_t'(1);
      else       w_next = at_zero ? MAX_D : r_q - digit_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_q <= '0;
    else if (load) r_q <= clamp_digit(load_d, DIGIT_MOD);
    else           r_q <= w_next;
  end

endmodule

// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: NUM_DIGITS cascaded modulo-DIGIT_MOD digits (default 2-digit BCD).
//   clk        : rising-edge clock, the only clock in the block
//   reset      : async active-high reset (count, wrap, ovf_sticky -> 0)
//   bus.slave  : en/up_dn/load/load_val/clr_ovf in, count/tc/wrap/ovf_sticky out
// Priority per edge: reset > load > en. The carry/borrow chain is combinational so
// all digits update on the same edge.
// Optional macro BCD_CNT_SATURATE_EN: hold at all-max (up) / all-zero (down) instead
// of wrapping; wrap still pulses and ovf_sticky still sets on each attempted step.
module bcd_counter_chain
  import bcd_cnt_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int DIGIT_MOD  = 10
) (
  input  logic              clk,
  input  logic              reset,
  bcd_counter_chain_if.slave bus
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  logic [NUM_DIGITS-1:0]              w_at_max;
  logic [NUM_DIGITS-1:0]              w_at_zero;
  logic [NUM_DIGITS-1:0]              w_step;
  // w_lo_*[i]: every digit below i is at max / zero (vacuously true for digit 0)
  logic [NUM_DIGITS:0]                w_lo_max;
  logic [NUM_DIGITS:0]                w_lo_zero;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_q;
  logic                               w_tc;
  logic                               w_hold;
  logic                               w_wrap_set;
  logic                               r_wrap;
  logic                               r_ovf;

  assign w_lo_max[0]  = 1'b1;
  assign w_lo_zero[0] = 1'b1;

  assign w_tc = bus.en & (bus.up_dn ? w_lo_max[NUM_DIGITS] : w_lo_zero[NUM_DIGITS]);

`ifdef BCD_CNT_SATURATE_EN
  // At the limit, freeze every digit rather than rolling over.
  assign w_hold = w_tc;
`else
  assign w_hold = 1'b0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_lo_max[g+1]  = w_lo_max[g]  & w_at_max[g];
    assign w_lo_zero[g+1] = w_lo_zero[g] & w_at_zero[g];
    assign w_step[g]      = bus.en & ~w_hold & (bus.up_dn ? w_lo_max[g] : w_lo_zero[g]);

    bcd_digit #(
      .DIGIT_MOD (DIGIT_MOD)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .load    (bus.load),
      .load_d  (bus.load_val[g*DIGIT_W +: DIGIT_W]),
      .step    (w_step[g]),
      .up_dn   (bus.up_dn),
      .q       (w_q[g]),
      .at_max  (w_at_max[g]),
      .at_zero (w_at_zero[g])
    );
  end

  // A terminal-count edge that is not overridden by load is a wrap (or saturate attempt).
  assign w_wrap_set = w_tc & ~bus.load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_set;
      if (w_wrap_set)       r_ovf <= 1'b1;  // set beats clear
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.count      = W'(w_q);
  assign bus.tc         = w_tc;
  assign bus.wrap       = r_wrap;
  assign bus.ovf_sticky = r_ovf;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain: a 2-digit BCD instance and a 1-digit mod-6 instance.
module tb_bcd_counter_chain;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_counter_chain_if #(.NUM_DIGITS(2)) bus ();
  bcd_counter_chain_if #(.NUM_DIGITS(1)) bus6 ();

  bcd_counter_chain #(.NUM_DIGITS(2), .DIGIT_MOD(10)) dut (
    .clk (clk), .reset (reset), .bus (bus)
  );

  bcd_counter_chain #(.NUM_DIGITS(1), .DIGIT_MOD(6)) dut6 (
    .clk (clk), .reset (reset), .bus (bus6)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  initial begin
    reset = 1'b1;
    bus.en = 0;  bus.up_dn = 1; bus.load = 0; bus.load_val = '0; bus.clr_ovf = 0;
    bus6.en = 0; bus6.up_dn = 1; bus6.load = 0; bus6.load_val = '0; bus6.clr_ovf = 0;
    #12;
    chk("rst_count", bus.count, 8'h00);
    chk("rst_wrap",  bus.wrap, 0);
    chk("rst_ovf",   bus.ovf_sticky, 0);
    chk("rst_tc",    bus.tc, 0);
    reset = 1'b0;

    // 1: full up sweep 00..99 -> 00
    bus.en = 1; bus.up_dn = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("up_count", bus.count, (k == 100) ? (SAT ? 8'h99 : 8'h00) : bcd(k));
      chk("up_wrap",  bus.wrap, (k == 100));
      chk("up_ovf",   bus.ovf_sticky, (k == 100));
      if (k == 50) chk("up_tc_mid", bus.tc, 0);
      if (k == 99) chk("up_tc_99", bus.tc, 1);
    end
    bus.en = 0;
    tick();
    chk("idle_wrap", bus.wrap, 0);
    chk("idle_ovf",  bus.ovf_sticky, 1);

    // 2: load beats en, then down-wrap from 00
    bus.en = 1; bus.up_dn = 0; bus.load = 1; bus.load_val = 8'h00;
    tick();
    chk("ld_en_count", bus.count, 8'h00);
    chk("ld_en_wrap",  bus.wrap, 0);
    bus.load = 0;
    #1 chk("dn_tc_00", bus.tc, 1);
    tick();
    chk("dn_wrap_count", bus.count, SAT ? 8'h00 : 8'h99);
    chk("dn_wrap_pulse", bus.wrap, 1);
    bus.en = 0;
    tick();
    chk("dn_wrap_clear", bus.wrap, 0);

    // borrow across digits
    bus.load = 1; bus.load_val = 8'h40;
    tick();
    bus.load = 0; bus.en = 1; bus.up_dn = 0;
    tick();
    chk("borrow", bus.count, 8'h39);
    chk("borrow_wrap", bus.wrap, 0);
    bus.en = 0; bus.up_dn = 1;
    tick();
    chk("hold_count", bus.count, 8'h39);
    chk("hold_tc", bus.tc, 0);

    // 3: load clamping
    bus.load = 1; bus.load_val = 8'h3F;
    tick();
    chk("clamp_lo", bus.count, 8'h39);
    bus.load_val = 8'hA2;
    tick();
    chk("clamp_hi", bus.count, 8'h92);
    bus.load = 0;

    // 4: async reset between edges
    bus.load = 1; bus.load_val = 8'h47;
    tick();
    bus.load = 0;
    chk("pre_rst_count", bus.count, 8'h47);
    chk("pre_rst_ovf", bus.ovf_sticky, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_count", bus.count, 8'h00);
    chk("async_rst_wrap",  bus.wrap, 0);
    chk("async_rst_ovf",   bus.ovf_sticky, 0);
    #1 reset = 1'b0;
    bus.en = 1; bus.up_dn = 1;
    tick();
    chk("post_rst_count", bus.count, 8'h01);
    chk("post_rst_ovf",   bus.ovf_sticky, 0);
    bus.en = 0;

    // 5: set beats clr_ovf
    bus.load = 1; bus.load_val = 8'h99;
    tick();
    bus.load = 0; bus.en = 1;
    tick();
    chk("ovf_set", bus.ovf_sticky, 1);
    bus.en = 0; bus.load = 1;
    tick();
    chk("ovf_keep_on_load", bus.ovf_sticky, 1);
    bus.load = 0; bus.en = 1; bus.up_dn = 1; bus.clr_ovf = 1;
    tick();
    chk("set_vs_clr_ovf",  bus.ovf_sticky, 1);
    chk("set_vs_clr_wrap", bus.wrap, 1);
    bus.en = 0;
    tick();
    chk("clr_ovf", bus.ovf_sticky, 0);
    chk("clr_wrap", bus.wrap, 0);
    bus.clr_ovf = 0;

    // 6: three steps at 99
    bus.load = 1; bus.load_val = 8'h99;
    tick();
    bus.load = 0; bus.en = 1; bus.up_dn = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("top_count", bus.count, SAT ? 8'h99 : bcd(k - 1));
      chk("top_wrap",  bus.wrap, SAT || (k == 1));
      chk("top_ovf",   bus.ovf_sticky, 1);
    end
    bus.en = 0;

    // mod-6 single digit
    bus6.en = 1; bus6.up_dn = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("m6_count", bus6.count, SAT ? ((k > 5) ? 5 : k) : (k % 6));
      chk("m6_wrap",  bus6.wrap, SAT ? (k >= 6) : (k == 6));
    end
    bus6.en = 0; bus6.load = 1; bus6.load_val = 4'h0;
    tick();
    bus6.load = 0; bus6.en = 1; bus6.up_dn = 0;
    tick();
    chk("m6_dn_count", bus6.count, SAT ? 0 : 5);
    chk("m6_dn_wrap",  bus6.wrap, 1);
    bus6.en = 0; bus6.load = 1; bus6.load_val = 4'h9;
    tick();
    chk("m6_clamp", bus6.count, 5);
    bus6.load = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
